// File: rtl/fd_skid_reg.sv
// Fetch-to-decode boundary register with a two-entry skid buffer.
// F_ready depends only on the state register, so decode stall never reaches fetch PC_en combinationally.
module fd_skid_reg #(
  parameter int          CNT_W = 16,
  parameter logic [31:0] NOP   = 32'h00000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             F_valid,
  input  logic [31:0]      F_Instr,
  input  logic [31:0]      F_PC,
  input  logic [31:0]      F_PCplus8,
  output logic             F_ready,
  input  logic             D_stall,
  output logic             D_valid,
  output logic [31:0]      D_Instr,
  output logic [31:0]      D_PC,
  output logic [31:0]      D_PCplus8,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp8;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           r_state, w_state_nx;
  entry_t           r_main, r_skid, w_in;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_consume;
  logic             w_ld_main_in, w_ld_main_skid, w_ld_skid;

  assign w_in      = '{instr: F_Instr, pc: F_PC, pcp8: F_PCplus8};
  assign F_ready   = (r_state != FULL);
  assign D_valid   = (r_state != EMPTY);
  assign w_accept  = F_valid & F_ready;
  assign w_consume = D_valid & ~D_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx     = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nx = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) begin
          w_ld_main_in = 1'b1;
          w_state_nx   = ONE;
        end
        ONE: begin
          if (w_consume && w_accept) begin
            w_ld_main_in = 1'b1;
          end else if (w_consume) begin
            w_state_nx = EMPTY;
          end else if (w_accept) begin
            w_ld_skid  = 1'b1;
            w_state_nx = FULL;
          end
        end
        FULL: if (w_consume) begin
          w_ld_main_skid = 1'b1;
          w_state_nx     = ONE;
        end
        default: w_state_nx = EMPTY;
      endcase
    end
  end

  // Flush only scrubs the instruction words; stale PCs are harmless once invalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else if (flush) begin
      r_main.instr <= NOP;
      r_skid.instr <= NOP;
    end else begin
      if (w_ld_main_in)        r_main <= w_in;
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)           r_skid <= w_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_cnt <= '0;
    else if (D_valid && D_stall && !(&r_cnt)) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign D_Instr   = D_valid ? r_main.instr : NOP;
  assign D_PC      = r_main.pc;
  assign D_PCplus8 = r_main.pcp8;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_fd_skid_reg.sv
// Directed bench for fd_skid_reg: vector table for stream/stall/flush, hand sequences for saturation and async reset.
module tb_fd_skid_reg;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, flush, F_valid, D_stall;
  logic [31:0]      F_Instr, F_PC, F_PCplus8;
  logic             F_ready, D_valid;
  logic [31:0]      D_Instr, D_PC, D_PCplus8;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;
  int seen_3010 = 0;

  fd_skid_reg #(.CNT_W(CNT_W), .NOP(32'h00000000)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .F_valid(F_valid), .F_Instr(F_Instr), .F_PC(F_PC), .F_PCplus8(F_PCplus8),
    .F_ready(F_ready), .D_stall(D_stall),
    .D_valid(D_valid), .D_Instr(D_Instr), .D_PC(D_PC), .D_PCplus8(D_PCplus8),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (D_valid && D_PC == 32'h3010) seen_3010++;

  typedef struct {
    bit          rst;
    bit          fl;
    bit          fv;
    logic [31:0] pc;
    bit          ds;
    bit          ev;
    logic [31:0] epc;
    bit          er;
    int          ec;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input bit fl, input bit fv, input logic [31:0] pc, input bit ds);
    flush     = fl;
    F_valid   = fv;
    F_PC      = pc;
    F_Instr   = instr_of(pc);
    F_PCplus8 = pc + 32'd8;
    D_stall   = ds;
  endtask

  task automatic add(input bit rst, input bit fl, input bit fv, input logic [31:0] pc, input bit ds,
                     input bit ev, input logic [31:0] epc, input bit er, input int ec);
    vec_t v;
    v = '{rst: rst, fl: fl, fv: fv, pc: pc, ds: ds, ev: ev, epc: epc, er: er, ec: ec};
    vecs.push_back(v);
  endtask

  task automatic chk_out(input string tag, input bit ev, input logic [31:0] epc, input bit er, input int ec);
    chk({tag, " D_valid"}, {31'd0, D_valid}, {31'd0, ev});
    chk({tag, " F_ready"}, {31'd0, F_ready}, {31'd0, er});
    chk({tag, " stall_cnt"}, {{(32-CNT_W){1'b0}}, stall_cnt}, ec);
    chk({tag, " D_Instr"}, D_Instr, ev ? instr_of(epc) : 32'h0);
    if (ev) begin
      chk({tag, " D_PC"}, D_PC, epc);
      chk({tag, " D_PCplus8"}, D_PCplus8, epc + 32'd8);
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 32'h0, 0);
    #12;
    reset = 1'b0;

    // rst fl fv pc ds | ev epc er ec  (expected = outputs before the edge of that cycle)
    add(0,0,1,32'h3000,0, 0,32'h0   ,1,0);
    add(0,0,1,32'h3004,0, 1,32'h3000,1,0);
    add(0,0,1,32'h3008,1, 1,32'h3004,1,0);
    add(0,0,1,32'h300C,0, 1,32'h3004,0,1);
    add(0,0,1,32'h300C,0, 1,32'h3008,1,1);
    add(0,0,0,32'h0   ,0, 1,32'h300C,1,1);
    add(0,0,0,32'h0   ,0, 0,32'h0   ,1,1);
    add(1,0,1,32'h3000,0, 0,32'h0   ,1,0);
    add(0,0,1,32'h3004,0, 1,32'h3000,1,0);
    add(0,0,1,32'h3008,1, 1,32'h3004,1,0);
    add(0,0,1,32'h300C,1, 1,32'h3004,0,1);
    add(0,0,1,32'h300C,1, 1,32'h3004,0,2);
    add(0,0,1,32'h300C,1, 1,32'h3004,0,3);
    add(0,0,1,32'h300C,1, 1,32'h3004,0,4);
    add(0,0,1,32'h300C,0, 1,32'h3004,0,5);
    add(0,0,1,32'h300C,1, 1,32'h3008,1,5);
    add(0,1,1,32'h3010,0, 1,32'h3008,0,6);
    add(0,0,1,32'h3020,0, 0,32'h0   ,1,6);
    add(0,0,0,32'h0   ,0, 1,32'h3020,1,6);
    add(0,0,0,32'h0   ,0, 0,32'h0   ,1,6);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].rst) begin
        reset = 1'b1;
        #1 reset = 1'b0;
      end
      drive(vecs[i].fl, vecs[i].fv, vecs[i].pc, vecs[i].ds);
      #1 chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].er, vecs[i].ec);
    end
    chk("flushed_3010_never_shown", seen_3010, 0);

    // Saturation: one valid entry held under stall for 20 cycles.
    @(negedge clk);
    reset = 1'b1;
    #1 reset = 1'b0;
    chk_out("sat_reset", 0, 32'h0, 1, 0);
    chk("sat_reset D_PC", D_PC, 32'h0);
    chk("sat_reset D_PCplus8", D_PCplus8, 32'h0);
    drive(0, 1, 32'h4000, 0);
    @(negedge clk);
    drive(0, 0, 32'h0, 1);
    for (int k = 0; k < 20; k++) begin
      #1 chk_out($sformatf("sat%0d", k), 1, 32'h4000, 1, (k > 15) ? 15 : k);
      @(negedge clk);
    end
    #1 chk_out("sat_end", 1, 32'h4000, 1, 15);

    // Async reset mid-cycle while FULL, no clock edge involved.
    @(negedge clk);
    drive(0, 1, 32'h5000, 0);
    @(negedge clk);
    drive(0, 1, 32'h5004, 1);
    @(negedge clk);
    drive(0, 1, 32'h5008, 1);
    #1 chk("full_before_reset F_ready", {31'd0, F_ready}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk_out("async_rst", 0, 32'h0, 1, 0);
    chk("async_rst D_PC", D_PC, 32'h0);
    chk("async_rst D_PCplus8", D_PCplus8, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 0);
    reset = 1'b0;
    @(negedge clk);
    #1 chk_out("post_rst_idle", 0, 32'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
